quiz_scoreboard: RTL and testbench

Parametrised scoreboard for the quiz responder. It holds one saturating score per player and applies judge "correct"/"wrong" decisions to the player who won the buzz. It detects the first player to reach the win threshold, latches that player as winner and freezes play until cleared. It sits between the buzzer/lockout logic (supplies `who`) and the seven-segment display driver (consumes BCD scores and winner).

---
 rtl/quiz_scoreboard.sv | 164 ++++++++++++++++
 tb/tb_quiz_scoreboard.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quiz_scoreboard.sv
// Quiz scoreboard: per-player saturating scores, judge event handling,
// first-to-threshold winner latch and BCD score output for the display driver.
//
// state   | meaning
// S_PLAY  | accepting judge events
// S_CHECK | one cycle: test adjusted player against the win threshold
// S_OVER  | winner latched, play frozen until clr/rst
module quiz_scoreboard #(
   parameter int NUM_PLAYERS = 4,
   parameter int SCORE_W     = 8,
   parameter int ID_W        = 4,
   parameter int WIN_SCORE   = 10,
   parameter int MAX_SCORE   = 99
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clr,
   input  logic                           judge_yes,
   input  logic                           judge_no,
   input  logic [ID_W-1:0]                who,
   input  logic [3:0]                     add_val,
   input  logic [3:0]                     sub_val,
   output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
   output logic [NUM_PLAYERS*8-1:0]       scores_bcd,
   output logic                           endgame,
   output logic [ID_W-1:0]                winner,
   output logic                           busy,
   output logic                           evt_ack,
   output logic                           evt_err
);

   typedef enum logic [1:0] {S_PLAY, S_CHECK, S_OVER} state_t;

   // Sum width keeps a full 4-bit addend even for very narrow score registers.
   localparam int SUM_W = (SCORE_W + 1 > 5) ? SCORE_W + 1 : 5;

   state_t              r_state;
   state_t              w_next_state;
   logic [SCORE_W-1:0]  r_score [NUM_PLAYERS];
   logic                r_yes_q;
   logic                r_no_q;
   logic [ID_W-1:0]     r_last_id;
   logic [ID_W-1:0]     r_winner;
   logic                r_ack;
   logic                r_err;

   logic                w_yes_rise;
   logic                w_no_rise;
   logic                w_any_rise;
   logic                w_single_rise;
   logic                w_who_ok;
   logic                w_apply;
   logic                w_reject;
   logic                w_win;
   logic [SCORE_W-1:0]  w_last_score;

   function automatic logic [SCORE_W-1:0] f_adjust(input logic [SCORE_W-1:0] s,
                                                   input logic up,
                                                   input logic [3:0] a,
                                                   input logic [3:0] d);
      logic [SUM_W-1:0] v;
      if (up) begin
         v = SUM_W'(s) + SUM_W'(a);
         if (v > SUM_W'(MAX_SCORE)) v = SUM_W'(MAX_SCORE);
      end else begin
         v = (SUM_W'(s) > SUM_W'(d)) ? SUM_W'(s) - SUM_W'(d) : '0;
      end
      return SCORE_W'(v);
   endfunction

   // Scores never exceed 99, so an 8-bit view is enough for the digit split.
   function automatic logic [7:0] f_bcd(input logic [SCORE_W-1:0] s);
      logic [7:0] v;
      v = 8'(s);
      return 8'(((v / 8'd10) << 4) | (v % 8'd10));
   endfunction

   assign w_yes_rise    = judge_yes & ~r_yes_q;
   assign w_no_rise     = judge_no & ~r_no_q;
   assign w_any_rise    = w_yes_rise | w_no_rise;
   assign w_single_rise = w_yes_rise ^ w_no_rise;
   assign w_who_ok      = (who != '0) && (who <= ID_W'(NUM_PLAYERS));
   assign w_apply       = !clr && (r_state == S_PLAY) && w_single_rise && w_who_ok;
   assign w_reject      = !clr && w_any_rise &&
                          (((r_state == S_PLAY) && !(w_single_rise && w_who_ok)) ||
                           (r_state == S_OVER));

   always_comb begin
      w_last_score = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         if (r_last_id == ID_W'(p + 1)) w_last_score = r_score[p];
      end
   end

   assign w_win = (w_last_score >= SCORE_W'(WIN_SCORE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_PLAY;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      if (clr) begin
         w_next_state = S_PLAY;
      end else begin
         case (r_state)
            S_PLAY:  if (w_apply) w_next_state = S_CHECK;
            S_CHECK: w_next_state = w_win ? S_OVER : S_PLAY;
            S_OVER:  w_next_state = S_OVER;
            default: w_next_state = S_PLAY;
         endcase
      end
   end

   always_comb begin
      busy    = (r_state == S_CHECK);
      endgame = (r_state == S_OVER);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < NUM_PLAYERS; p++) r_score[p] <= '0;
         r_yes_q   <= 1'b0;
         r_no_q    <= 1'b0;
         r_last_id <= '0;
         r_winner  <= '0;
         r_ack     <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_yes_q <= judge_yes;
         r_no_q  <= judge_no;
         r_ack   <= w_apply;
         r_err   <= w_reject;
         if (clr) begin
            for (int p = 0; p < NUM_PLAYERS; p++) r_score[p] <= '0;
            r_winner <= '0;
         end else begin
            if (w_apply) begin
               r_last_id <= who;
               for (int p = 0; p < NUM_PLAYERS; p++) begin
                  if (who == ID_W'(p + 1))
                     r_score[p] <= f_adjust(r_score[p], w_yes_rise, add_val, sub_val);
               end
            end
            if ((r_state == S_CHECK) && w_win) r_winner <= r_last_id;
         end
      end
   end

   always_comb begin
      scores     = '0;
      scores_bcd = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         scores[p*SCORE_W +: SCORE_W] = r_score[p];
         scores_bcd[p*8 +: 8]         = f_bcd(r_score[p]);
      end
   end

   assign winner  = r_winner;
   assign evt_ack = r_ack;
   assign evt_err = r_err;

endmodule

// File: tb/tb_quiz_scoreboard.sv
// Bench for quiz_scoreboard: a default instance and an 8-player/7-bit instance
// share stimulus and are both compared each cycle against a rule-level model.
module tb_quiz_scoreboard;

   logic       clk = 1'b0;
   logic       rst, clr, judge_yes, judge_no;
   logic [3:0] who, add_val, sub_val;

   logic [31:0] scores_a;
   logic [31:0] bcd_a;
   logic        endgame_a, busy_a, ack_a, err_a;
   logic [3:0]  winner_a;
   logic [55:0] scores_b;
   logic [63:0] bcd_b;
   logic        endgame_b, busy_b, ack_b, err_b;
   logic [3:0]  winner_b;

   int n_vec  = 0;
   int n_miss = 0;

   localparam int P_N   [2] = '{4, 8};
   localparam int P_SW  [2] = '{8, 7};
   localparam int P_WIN [2] = '{10, 99};
   localparam int P_MAX [2] = '{99, 99};

   // Model: st 0=playing, 1=checking, 2=game over
   int m_sc  [2][16];
   int m_st  [2];
   int m_last[2];
   int m_win [2];
   bit m_ack [2];
   bit m_err [2];
   bit m_yq  [2];
   bit m_nq  [2];

   quiz_scoreboard u_dut_a (
      .clk(clk), .rst(rst), .clr(clr), .judge_yes(judge_yes), .judge_no(judge_no),
      .who(who), .add_val(add_val), .sub_val(sub_val),
      .scores(scores_a), .scores_bcd(bcd_a), .endgame(endgame_a), .winner(winner_a),
      .busy(busy_a), .evt_ack(ack_a), .evt_err(err_a)
   );

   quiz_scoreboard #(.NUM_PLAYERS(8), .SCORE_W(7), .ID_W(4), .WIN_SCORE(99), .MAX_SCORE(99)) u_dut_b (
      .clk(clk), .rst(rst), .clr(clr), .judge_yes(judge_yes), .judge_no(judge_no),
      .who(who), .add_val(add_val), .sub_val(sub_val),
      .scores(scores_b), .scores_bcd(bcd_b), .endgame(endgame_b), .winner(winner_b),
      .busy(busy_b), .evt_ack(ack_b), .evt_err(err_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         for (int p = 0; p < 16; p++) m_sc[i][p] = 0;
         m_st[i] = 0; m_last[i] = 0; m_win[i] = 0;
         m_ack[i] = 0; m_err[i] = 0; m_yq[i] = 0; m_nq[i] = 0;
      end
   endtask

   task automatic model_step(input int i);
      bit yr, nr;
      int s, id;
      yr = judge_yes && !m_yq[i];
      nr = judge_no && !m_nq[i];
      id = int'(who);
      m_ack[i] = 0;
      m_err[i] = 0;
      if (clr) begin
         for (int p = 0; p < 16; p++) m_sc[i][p] = 0;
         m_win[i] = 0;
         m_st[i]  = 0;
      end else begin
         case (m_st[i])
            0: if (yr || nr) begin
                  if (yr && nr) m_err[i] = 1;
                  else if (id >= 1 && id <= P_N[i]) begin
                     s = m_sc[i][id-1];
                     if (yr) s = (s + int'(add_val) > P_MAX[i]) ? P_MAX[i] : s + int'(add_val);
                     else    s = (s > int'(sub_val)) ? s - int'(sub_val) : 0;
                     m_sc[i][id-1] = s;
                     m_last[i] = id;
                     m_ack[i]  = 1;
                     m_st[i]   = 1;
                  end else m_err[i] = 1;
               end
            1: if (m_sc[i][m_last[i]-1] >= P_WIN[i]) begin
                  m_win[i] = m_last[i];
                  m_st[i]  = 2;
               end else m_st[i] = 0;
            default: if (yr || nr) m_err[i] = 1;
         endcase
      end
      m_yq[i] = judge_yes;
      m_nq[i] = judge_no;
   endtask

   task automatic check_inst(input int i, input logic [63:0] sc, input logic [63:0] bcd,
                             input logic eg, input logic [3:0] wn, input logic bz,
                             input logic ak, input logic er);
      logic [63:0] e_sc, e_bcd;
      string nm;
      nm    = (i == 0) ? "A" : "B";
      e_sc  = '0;
      e_bcd = '0;
      for (int p = 0; p < P_N[i]; p++) begin
         e_sc  |= 64'(m_sc[i][p]) << (p * P_SW[i]);
         e_bcd |= 64'((m_sc[i][p] / 10) * 16 + m_sc[i][p] % 10) << (p * 8);
      end
      chk({nm, " scores"},     sc,       e_sc);
      chk({nm, " scores_bcd"}, bcd,      e_bcd);
      chk({nm, " endgame"},    64'(eg),  64'(m_st[i] == 2));
      chk({nm, " winner"},     64'(wn),  64'(m_win[i]));
      chk({nm, " busy"},       64'(bz),  64'(m_st[i] == 1));
      chk({nm, " evt_ack"},    64'(ak),  64'(m_ack[i]));
      chk({nm, " evt_err"},    64'(er),  64'(m_err[i]));
   endtask

   task automatic check_all();
      check_inst(0, 64'(scores_a), 64'(bcd_a), endgame_a, winner_a, busy_a, ack_a, err_a);
      check_inst(1, 64'(scores_b), bcd_b, endgame_b, winner_b, busy_b, ack_b, err_b);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         model_step(0);
         model_step(1);
         #1;
         check_all();
      end
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; judge_yes = 1'b0; judge_no = 1'b0;
      who = 4'd0; add_val = 4'd0; sub_val = 4'd0;
      model_reset();
      #3;
      check_all();
      #4 rst = 1'b0;
      step(1);

      // player 2 scores 3
      who = 4'd2; add_val = 4'd3; judge_yes = 1'b1; step(1);
      chk("p2 score", 64'(scores_a[15:8]), 64'd3);
      chk("p2 bcd", 64'(bcd_a[15:8]), 64'h03);
      chk("p2 ack", 64'(ack_a), 64'd1);
      step(1);
      chk("ack one cycle", 64'(ack_a), 64'd0);
      judge_yes = 1'b0; step(1);

      // player 1 to 2, then deduction floors at 0, then a held level counts once
      who = 4'd1; add_val = 4'd2; judge_yes = 1'b1; step(1); judge_yes = 1'b0; step(2);
      sub_val = 4'd5; judge_no = 1'b1; step(1);
      chk("p1 floor", 64'(scores_a[7:0]), 64'd0);
      judge_no = 1'b0; step(2);
      add_val = 4'd1; judge_yes = 1'b1; step(10); judge_yes = 1'b0; step(1);
      chk("p1 held once", 64'(scores_a[7:0]), 64'd1);

      // player 3 reaches 12 and wins; later rises rejected; clr restarts
      who = 4'd3; add_val = 4'd8; judge_yes = 1'b1; step(1); judge_yes = 1'b0; step(2);
      add_val = 4'd4; judge_yes = 1'b1; step(1);
      chk("p3 bcd 12", 64'(bcd_a[23:16]), 64'h12);
      step(1);
      chk("win endgame", 64'(endgame_a), 64'd1);
      chk("win id", 64'(winner_a), 64'd3);
      judge_yes = 1'b0; step(1);
      judge_yes = 1'b1; step(1);
      chk("over err", 64'(err_a), 64'd1);
      judge_yes = 1'b0; step(1);
      clr = 1'b1; step(1); clr = 1'b0;
      chk("clr winner", 64'(winner_a), 64'd0);
      chk("clr scores", 64'(scores_a), 64'd0);
      step(1);

      // simultaneous rises, nobody, out-of-range player
      who = 4'd1; judge_yes = 1'b1; judge_no = 1'b1; step(1);
      chk("both err", 64'(err_a), 64'd1);
      judge_yes = 1'b0; judge_no = 1'b0; step(1);
      who = 4'd0; judge_yes = 1'b1; step(1);
      chk("who0 err", 64'(err_a), 64'd1);
      judge_yes = 1'b0; step(1);
      who = 4'd5; judge_yes = 1'b1; step(1);
      chk("who5 err", 64'(err_a), 64'd1);
      judge_yes = 1'b0; step(2);

      // rise while checking is dropped and not replayed
      who = 4'd1; add_val = 4'd1; judge_yes = 1'b1; step(1);
      judge_no = 1'b1; step(1);
      chk("check drop ack", 64'(ack_a), 64'd0);
      chk("check drop err", 64'(err_a), 64'd0);
      step(2);
      judge_yes = 1'b0; judge_no = 1'b0; step(1);

      // 8-player instance: player 8 climbs to 97, then saturates at 99 and wins
      who = 4'd8; add_val = 4'd15;
      repeat (6) begin judge_yes = 1'b1; step(1); judge_yes = 1'b0; step(2); end
      add_val = 4'd7; judge_yes = 1'b1; step(1); judge_yes = 1'b0; step(2);
      chk("p8 at 97", 64'(scores_b[55:49]), 64'd97);
      add_val = 4'd9; judge_yes = 1'b1; step(1);
      chk("p8 saturate", 64'(scores_b[55:49]), 64'd99);
      step(1);
      chk("p8 winner", 64'(winner_b), 64'd8);
      judge_yes = 1'b0; step(1);

      // rst asserted while checking
      clr = 1'b1; step(1); clr = 1'b0;
      who = 4'd1; add_val = 4'd2; judge_yes = 1'b1; step(1);
      chk("pre-rst busy", 64'(busy_a), 64'd1);
      #1 rst = 1'b1;
      #1;
      model_reset();
      check_all();
      judge_yes = 1'b0;
      #1 rst = 1'b0;
      step(2);

      // randomized play
      repeat (400) begin
         clr       = ($urandom_range(0, 39) == 0);
         judge_yes = ($urandom_range(0, 2) == 0);
         judge_no  = ($urandom_range(0, 3) == 0);
         who       = 4'($urandom_range(0, 9));
         add_val   = 4'($urandom_range(0, 15));
         sub_val   = 4'($urandom_range(0, 15));
         step(1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
